// File: rtl/gpio_arbiter.sv
// gpio_arbiter: two-master round-robin arbiter in front of the single-register
// GPIO peripheral. Serialises accesses, absorbs the peripheral's one-cycle
// read latency and returns a per-master ack with read data.
module gpio_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [7:0] m0_wdata,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [7:0] m1_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       g_ren,
  output logic       g_wen,
  output logic [7:0] g_wdata,
  input  logic [7:0] g_rdata,
  output logic       busy,
  output logic       gnt_id
);

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            last_gnt, last_gnt_n;
  logic            we_q, we_n;
  logic            gnt_id_n;
  logic            win_c;
  logic            g_ren_n, g_wen_n;
  logic [DW-1:0]   g_wdata_n;
  logic            m0_ack_n, m1_ack_n;
  logic [DW-1:0]   m0_rdata_n, m1_rdata_n;
  logic            busy_n;

  // Next-state and next-output decode; requests are only looked at in IDLE
  always_comb begin
    state_n    = state;
    last_gnt_n = last_gnt;
    we_n       = we_q;
    gnt_id_n   = gnt_id;
    win_c      = 1'b0;
    g_ren_n    = 1'b0;
    g_wen_n    = 1'b0;
    g_wdata_n  = g_wdata;
    m0_ack_n   = 1'b0;
    m1_ack_n   = 1'b0;
    m0_rdata_n = m0_rdata;
    m1_rdata_n = m1_rdata;

    case (state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // Contention goes to whoever was not served last
          win_c     = (m0_req && m1_req) ? ~last_gnt : m1_req;
          gnt_id_n  = win_c;
          we_n      = win_c ? m1_we : m0_we;
          g_wdata_n = win_c ? m1_wdata : m0_wdata;
          g_ren_n   = ~we_n;
          g_wen_n   = we_n;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Peripheral read data is valid now; capture it for the granted master
        if (!we_q) begin
          if (gnt_id) m1_rdata_n = g_rdata;
          else        m0_rdata_n = g_rdata;
        end
        if (gnt_id) m1_ack_n = 1'b1;
        else        m0_ack_n = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: begin
        last_gnt_n = gnt_id;
        state_n    = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      gnt_id   <= 1'b0;
      g_ren    <= 1'b0;
      g_wen    <= 1'b0;
      g_wdata  <= DW'(0);
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= DW'(0);
      m1_rdata <= DW'(0);
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      last_gnt <= last_gnt_n;
      we_q     <= we_n;
      gnt_id   <= gnt_id_n;
      g_ren    <= g_ren_n;
      g_wen    <= g_wen_n;
      g_wdata  <= g_wdata_n;
      m0_ack   <= m0_ack_n;
      m1_ack   <= m1_ack_n;
      m0_rdata <= m0_rdata_n;
      m1_rdata <= m1_rdata_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_gpio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 1'b0, m0_we = 1'b0;
  logic [7:0] m0_wdata = 8'h00;
  logic       m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0] m1_wdata = 8'h00;
  logic       m0_ack, m1_ack, g_ren, g_wen, busy, gnt_id;
  logic [7:0] m0_rdata, m1_rdata, g_wdata;
  logic [7:0] g_rdata;
  logic [7:0] in_pins = 8'h00;
  logic [7:0] out_pins;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .g_ren(g_ren), .g_wen(g_wen), .g_wdata(g_wdata), .g_rdata(g_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Single-register GPIO peripheral: registered read, write to output pins
  always_ff @(posedge clk) begin
    if (g_ren) g_rdata <= in_pins;
    if (g_wen) out_pins <= g_wdata;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per transaction, outputs derived from the
  // number of clock edges since the grant edge.
  int         cyc;
  bit         m_act;
  int         m_t0;
  bit         m_win, m_we, m_last, m_gnt;
  logic [7:0] m_gwd, m_cap, m_rd0, m_rd1;

  task automatic mdl_reset();
    m_act  = 1'b0;
    m_t0   = 0;
    m_last = 1'b1;
    m_gnt  = 1'b0;
    m_we   = 1'b0;
    m_win  = 1'b0;
    m_gwd  = 8'h00;
    m_cap  = 8'h00;
    m_rd0  = 8'h00;
    m_rd1  = 8'h00;
  endtask

  initial begin
    cyc = 0;
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mdl_reset();
      end else begin
        cyc++;
        if (m_act && (cyc - m_t0) == 1) m_cap = in_pins;
        if (m_act && (cyc - m_t0) == 2 && !m_we) begin
          if (m_win) m_rd1 = m_cap;
          else       m_rd0 = m_cap;
        end
        if ((!m_act || (cyc - m_t0) >= 4) && (m0_req || m1_req)) begin
          m_win  = (m0_req && m1_req) ? !m_last : m1_req;
          m_last = m_win;
          m_gnt  = m_win;
          m_we   = m_win ? m1_we : m0_we;
          m_gwd  = m_win ? m1_wdata : m0_wdata;
          m_t0   = cyc;
          m_act  = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    int k;
    bit live;
    forever begin
      @(negedge clk);
      k    = cyc - m_t0;
      live = m_act && (k >= 0) && (k <= 2);
      chk("busy",     8'(busy),   8'(live));
      chk("g_ren",    8'(g_ren),  8'(m_act && k == 0 && !m_we));
      chk("g_wen",    8'(g_wen),  8'(m_act && k == 0 && m_we));
      chk("g_wdata",  g_wdata,    m_gwd);
      chk("gnt_id",   8'(gnt_id), 8'(m_gnt));
      chk("m0_ack",   8'(m0_ack), 8'(m_act && k == 2 && !m_win));
      chk("m1_ack",   8'(m1_ack), 8'(m_act && k == 2 && m_win));
      chk("m0_rdata", m0_rdata,   m_rd0);
      chk("m1_rdata", m1_rdata,   m_rd1);
      chk("excl",     8'(g_ren && g_wen), 8'h00);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  8'(busy),   8'h00);
    chk("rst_ren",   8'(g_ren),  8'h00);
    chk("rst_wen",   8'(g_wen),  8'h00);
    chk("rst_wdata", g_wdata,    8'h00);
    chk("rst_ack0",  8'(m0_ack), 8'h00);
    chk("rst_ack1",  8'(m1_ack), 8'h00);
    chk("rst_rd0",   m0_rdata,   8'h00);
    chk("rst_rd1",   m1_rdata,   8'h00);
    chk("rst_gnt",   8'(gnt_id), 8'h00);
    step(2);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         ids [8];
    int         cycs[8];

    // Power-on reset
    step(2);
    chk("por_busy", 8'(busy), 8'h00);
    chk("por_rd0",  m0_rdata, 8'h00);
    #2 rst_n = 1'b1;
    step(1);

    // Single read by m0
    in_pins = 8'hA5;
    m0_we = 1'b0; m0_req = 1'b1;
    step(1);
    chk("rd_ren_c1",  8'(g_ren),  8'h01);
    chk("rd_gnt_c1",  8'(gnt_id), 8'h00);
    step(1);
    chk("rd_ren_c2",  8'(g_ren),  8'h00);
    step(1);
    chk("rd_ack_c3",  8'(m0_ack), 8'h01);
    chk("rd_data_c3", m0_rdata,   8'hA5);
    chk("rd_ack1_c3", 8'(m1_ack), 8'h00);
    m0_req = 1'b0;
    step(1);
    chk("rd_ack_c4",  8'(m0_ack), 8'h00);
    chk("rd_busy_c4", 8'(busy),   8'h00);
    chk("rd_rd1_c4",  m1_rdata,   8'h00);

    // Single write by m1
    m1_we = 1'b1; m1_wdata = 8'h3C; m1_req = 1'b1;
    step(1);
    chk("wr_wen_c1",   8'(g_wen),  8'h01);
    chk("wr_wdata_c1", g_wdata,    8'h3C);
    chk("wr_gnt_c1",   8'(gnt_id), 8'h01);
    step(1);
    chk("wr_wen_c2",   8'(g_wen),  8'h00);
    step(1);
    chk("wr_ack_c3",   8'(m1_ack), 8'h01);
    chk("wr_rd1_c3",   m1_rdata,   8'h00);
    m1_req = 1'b0;
    step(1);
    chk("wr_pins",     out_pins,   8'h3C);

    // Contention right after reset: m0 wins first
    do_reset();
    m0_we = 1'b1; m0_wdata = 8'h11;
    m1_we = 1'b1; m1_wdata = 8'h22;
    m0_req = 1'b1; m1_req = 1'b1;
    step(1);
    chk("ct_gnt_c1",   8'(gnt_id), 8'h00);
    chk("ct_wdata_c1", g_wdata,    8'h11);
    step(2);
    chk("ct_ack0_c3",  8'(m0_ack), 8'h01);
    m0_req = 1'b0;
    step(2);
    chk("ct_gnt_c5",   8'(gnt_id), 8'h01);
    chk("ct_wdata_c5", g_wdata,    8'h22);
    step(2);
    chk("ct_ack1_c7",  8'(m1_ack), 8'h01);
    m1_req = 1'b0;
    step(1);
    chk("ct_pins",     out_pins,   8'h22);

    // Fairness: both requesters hold req for 8 transactions
    in_pins = 8'h6E;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        ids[n]  = m1_ack ? 1 : 0;
        cycs[n] = c;
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("fair_count", 8'(n), 8'd8);
    for (int i = 0; i < n; i++) begin
      chk("fair_id", 8'(ids[i]), 8'(i % 2));
      if (i > 0) chk("fair_gap", 8'(cycs[i] - cycs[i-1]), 8'd4);
    end
    step(1);

    // Reset during WAIT of an m0 read, then a fresh read
    in_pins = 8'h5A;
    m0_we = 1'b0; m0_req = 1'b1;
    step(2);
    chk("mr_busy_wait", 8'(busy), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", 8'(busy),   8'h00);
    chk("mr_ren",  8'(g_ren),  8'h00);
    chk("mr_ack0", 8'(m0_ack), 8'h00);
    chk("mr_rd0",  m0_rdata,   8'h00);
    chk("mr_rd1",  m1_rdata,   8'h00);
    chk("mr_gnt",  8'(gnt_id), 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mr_noack", 8'(m0_ack), 8'h00);
    end
    #2 rst_n = 1'b1;
    step(1);
    chk("mr2_ren_c1",  8'(g_ren),  8'h01);
    step(2);
    chk("mr2_ack_c3",  8'(m0_ack), 8'h01);
    chk("mr2_data_c3", m0_rdata,   8'h5A);
    m0_req = 1'b0;
    step(1);

    // m1 requests during m0's ISSUE: waits for the next IDLE
    m0_we = 1'b1; m0_wdata = 8'h77; m0_req = 1'b1;
    step(1);
    chk("lt_gnt_c1",   8'(gnt_id), 8'h00);
    m1_we = 1'b1; m1_wdata = 8'h99; m1_req = 1'b1;
    step(1);
    chk("lt_wdata_c2", g_wdata,    8'h77);
    chk("lt_gnt_c2",   8'(gnt_id), 8'h00);
    step(1);
    chk("lt_ack0_c3",  8'(m0_ack), 8'h01);
    chk("lt_ack1_c3",  8'(m1_ack), 8'h00);
    m0_req = 1'b0;
    step(1);
    chk("lt_busy_c4",  8'(busy),   8'h00);
    step(1);
    chk("lt_gnt_c5",   8'(gnt_id), 8'h01);
    chk("lt_wen_c5",   8'(g_wen),  8'h01);
    chk("lt_wdata_c5", g_wdata,    8'h99);
    step(2);
    chk("lt_ack1_c7",  8'(m1_ack), 8'h01);
    m1_req = 1'b0;
    step(1);
    chk("lt_pins",     out_pins,   8'h99);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
